// File: rtl/sort_result_streamer_if.sv
// ------------------------------------------------------------------------
// sort_result_streamer_if: vector-in / element-out handshake bundle. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

interface sort_result_streamer_if #(
  parameter int  WIDTH = 32,
  parameter int  DEPTH = 8,
  localparam int IDXW  = $clog2(DEPTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data [0:DEPTH-1];
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [IDXW-1:0]  out_index;
  logic             out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last
  );
endinterface

`default_nettype wire

// File: rtl/sort_result_streamer.sv
// ------------------------------------------------------------------------
// sort_result_streamer: streams a captured sorted vector one element per cycle.
// SORT_STREAM_DOUBLE_BUF_EN adds a hold buffer for zero-bubble streaming. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module sort_result_streamer #(
  parameter int  WIDTH = 32,
  parameter int  DEPTH = 8,
  localparam int IDXW  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  sort_result_streamer_if.slave s
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

  state_t           state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] sbuf [0:DEPTH-1];
  logic             out_valid_q;

  logic             in_hs;
  logic             out_hs;
  logic             at_last;
  logic             last_hs;

`ifdef SORT_STREAM_DOUBLE_BUF_EN
  logic [WIDTH-1:0] hbuf [0:DEPTH-1];
  logic             hvalid;

  assign s.in_ready = !hvalid;
`else
  logic             in_ready_q;

  assign s.in_ready = in_ready_q;
`endif

  assign in_hs   = s.in_valid && s.in_ready;
  assign out_hs  = out_valid_q && s.out_ready;
  assign at_last = (idx == LAST_IDX);
  assign last_hs = out_hs && at_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) sbuf[i] <= '0;
`ifdef SORT_STREAM_DOUBLE_BUF_EN
      hvalid      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) hbuf[i] <= '0;
`else
      in_ready_q  <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_hs) begin
            for (int i = 0; i < DEPTH; i++) sbuf[i] <= s.in_data[i];
            idx         <= '0;
            state       <= STREAM;
            out_valid_q <= 1'b1;
`ifndef SORT_STREAM_DOUBLE_BUF_EN
            in_ready_q  <= 1'b0;
`endif
          end
        end
        STREAM: begin
          if (out_hs && !at_last) idx <= idx + 1'b1;
`ifdef SORT_STREAM_DOUBLE_BUF_EN
          // hvalid=1 forces in_ready=0, so a hold-to-stream swap never races a capture
          if (last_hs) begin
            idx <= '0;
            if (hvalid) begin
              for (int i = 0; i < DEPTH; i++) sbuf[i] <= hbuf[i];
              hvalid <= 1'b0;
            end else if (in_hs) begin
              for (int i = 0; i < DEPTH; i++) sbuf[i] <= s.in_data[i];
            end else begin
              state       <= IDLE;
              out_valid_q <= 1'b0;
            end
          end else if (in_hs) begin
            for (int i = 0; i < DEPTH; i++) hbuf[i] <= s.in_data[i];
            hvalid <= 1'b1;
          end
`else
          if (last_hs) begin
            idx         <= '0;
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
`endif
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Output side is a pure register mux; IDLE shows a stale element under out_valid=0
  assign s.out_valid = out_valid_q;
  assign s.out_data  = sbuf[idx];
  assign s.out_index = idx;
  assign s.out_last  = out_valid_q && at_last;

endmodule

`default_nettype wire

// File: tb/tb_sort_result_streamer.sv
// ------------------------------------------------------------------------
// tb_sort_result_streamer: directed self-checking bench for sort_result_streamer. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_sort_result_streamer;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int IDXW  = 3;

  logic clk;
  logic rst;

  sort_result_streamer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sort_result_streamer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic [WIDTH-1:0] vecs [0:3][0:DEPTH-1];

  logic [WIDTH-1:0] rec_data [$];
  logic [IDXW-1:0]  rec_idx  [$];
  logic             rec_last [$];

  int   gaps;
  int   stab_err;
  int   taken_at_stall;
  logic ir_at_stall;

  always @(posedge clk) begin
    if (rst !== 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      rec_data.push_back(bus.out_data);
      rec_idx.push_back(bus.out_index);
      rec_last.push_back(bus.out_last);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic drive_vec(input int n);
    for (int e = 0; e < DEPTH; e++) bus.in_data[e] = vecs[n][e];
  endtask

  // mode 0: out_ready=1; mode 1: pattern 1,0,0,1; mode 2: 0 for 'stall' cycles then 1
  task automatic run_vectors(input int nvec, input int max_cycles, input int mode, input int stall);
    int   n;
    logic hs_in;
    logic pv_hold;
    logic seen_valid;
    logic [WIDTH+IDXW+1:0] prev;
    logic [3:0] pat;
    pat = 4'b1001;
    rec_data.delete(); rec_idx.delete(); rec_last.delete();
    gaps = 0; stab_err = 0; taken_at_stall = -1; ir_at_stall = 1'bx;
    n = 0; pv_hold = 1'b0; seen_valid = 1'b0; prev = '0;
    for (int cyc = 0; cyc < max_cycles && rec_data.size() < nvec * DEPTH; cyc++) begin
      bus.in_valid = (n < nvec);
      if (n < nvec) drive_vec(n);
      case (mode)
        1:       bus.out_ready = pat[3 - (cyc % 4)];
        2:       bus.out_ready = (cyc >= stall);
        default: bus.out_ready = 1'b1;
      endcase
      #0;
      if (pv_hold && {bus.out_valid, bus.out_data, bus.out_index, bus.out_last} !== prev) stab_err++;
      if (bus.out_valid) seen_valid = 1'b1;
      else if (seen_valid) gaps++;
      if (cyc == stall) begin
        ir_at_stall    = bus.in_ready;
        taken_at_stall = n;
      end
      hs_in   = bus.in_valid && bus.in_ready;
      pv_hold = bus.out_valid && !bus.out_ready;
      prev    = {bus.out_valid, bus.out_data, bus.out_index, bus.out_last};
      @(posedge clk); #1;
      if (hs_in) n++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    logic [WIDTH+IDXW+2:0] got, exp;
    rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    for (int e = 0; e < DEPTH; e++) bus.in_data[e] = '1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    got = {bus.in_ready, bus.out_valid, bus.out_data, bus.out_index, bus.out_last};
    exp = {1'b1, 1'b0, 32'd0, 3'd0, 1'b0};
    checks++;
    if (got !== exp) $display("FAIL reset_state: got %h expected %h", got, exp);
    else passed++;
  endtask

  task automatic test_full_rate();
    logic [WIDTH+IDXW+1:0] got, exp;
    for (int e = 0; e < DEPTH; e++) vecs[0][e] = 32'(10 * (e + 1));
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    drive_vec(0);
    checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL full_rate_in_ready_idle: got %b expected 1", bus.in_ready);
    else passed++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      got = {bus.out_valid, bus.out_data, bus.out_index, bus.out_last};
      exp = {1'b1, 32'(10 * (k + 1)), 3'(k), (k == DEPTH - 1)};
      checks++;
      if (got !== exp) $display("FAIL full_rate_elem%0d: got %h expected %h", k, got, exp);
      else passed++;
      checks++;
`ifdef SORT_STREAM_DOUBLE_BUF_EN
      if (bus.in_ready !== 1'b1) $display("FAIL full_rate_in_ready%0d: got %b expected 1", k, bus.in_ready);
`else
      if (bus.in_ready !== 1'b0) $display("FAIL full_rate_in_ready%0d: got %b expected 0", k, bus.in_ready);
`endif
      else passed++;
      @(posedge clk); #1;
    end
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01)
      $display("FAIL full_rate_after_last: got valid/ready %b expected 01", {bus.out_valid, bus.in_ready});
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [WIDTH+IDXW:0] got, exp;
    for (int e = 0; e < DEPTH; e++) vecs[0][e] = 32'(10 * (e + 1));
    run_vectors(1, 80, 1, 0);
    checks++;
    if (stab_err !== 0) $display("FAIL backpressure_hold: got %0d unstable cycles expected 0", stab_err);
    else passed++;
    checks++;
    if (rec_data.size() !== DEPTH) $display("FAIL backpressure_count: got %0d expected %0d", rec_data.size(), DEPTH);
    else passed++;
    for (int i = 0; i < rec_data.size(); i++) begin
      got = {rec_data[i], rec_idx[i], rec_last[i]};
      exp = {32'(10 * (i + 1)), 3'(i), (i == DEPTH - 1)};
      checks++;
      if (got !== exp) $display("FAIL backpressure_elem%0d: got %h expected %h", i, got, exp);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH+IDXW:0] got, exp;
    for (int e = 0; e < DEPTH; e++) begin
      vecs[0][e] = 32'(e + 1);
      vecs[1][e] = 32'(e + 9);
    end
    run_vectors(2, 60, 0, 0);
    checks++;
    if (rec_data.size() !== 2 * DEPTH) $display("FAIL b2b_count: got %0d expected %0d", rec_data.size(), 2 * DEPTH);
    else passed++;
    checks++;
`ifdef SORT_STREAM_DOUBLE_BUF_EN
    if (gaps !== 0) $display("FAIL b2b_bubbles: got %0d expected 0", gaps);
`else
    if (gaps !== 1) $display("FAIL b2b_bubbles: got %0d expected 1", gaps);
`endif
    else passed++;
    for (int i = 0; i < rec_data.size(); i++) begin
      got = {rec_data[i], rec_idx[i], rec_last[i]};
      exp = {32'(i + 1), 3'(i % DEPTH), ((i % DEPTH) == DEPTH - 1)};
      checks++;
      if (got !== exp) $display("FAIL b2b_elem%0d: got %h expected %h", i, got, exp);
      else passed++;
    end
  endtask

  task automatic test_hold_buffer();
    logic [WIDTH+IDXW:0] got, exp;
    for (int e = 0; e < DEPTH; e++) begin
      vecs[0][e] = 32'h100 + 32'(e);
      vecs[1][e] = 32'h200 + 32'(e);
      vecs[2][e] = 32'h300 + 32'(e);
    end
    run_vectors(3, 90, 2, 4);
    checks++;
    if (ir_at_stall !== 1'b0) $display("FAIL hold_in_ready: got %b expected 0", ir_at_stall);
    else passed++;
    checks++;
`ifdef SORT_STREAM_DOUBLE_BUF_EN
    if (taken_at_stall !== 2) $display("FAIL hold_taken: got %0d expected 2", taken_at_stall);
`else
    if (taken_at_stall !== 1) $display("FAIL hold_taken: got %0d expected 1", taken_at_stall);
`endif
    else passed++;
    checks++;
    if (rec_data.size() !== 3 * DEPTH) $display("FAIL hold_count: got %0d expected %0d", rec_data.size(), 3 * DEPTH);
    else passed++;
    for (int i = 0; i < rec_data.size(); i++) begin
      got = {rec_data[i], rec_idx[i], rec_last[i]};
      exp = {32'(((i / DEPTH) + 1) * 256 + (i % DEPTH)), 3'(i % DEPTH), ((i % DEPTH) == DEPTH - 1)};
      checks++;
      if (got !== exp) $display("FAIL hold_elem%0d: got %h expected %h", i, got, exp);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH+IDXW+2:0] got, exp;
    logic [WIDTH+IDXW:0]   g2, e2;
    for (int e = 0; e < DEPTH; e++) vecs[0][e] = 32'(10 * (e + 1));
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    drive_vec(0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int t = 0; t < 12 && !(bus.out_valid === 1'b1 && bus.out_index === 3'd3); t++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (bus.out_index !== 3'd3) $display("FAIL reset_mid_reach: got index %0d expected 3", bus.out_index);
    else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    got = {bus.in_ready, bus.out_valid, bus.out_data, bus.out_index, bus.out_last};
    exp = {1'b1, 1'b0, 32'd0, 3'd0, 1'b0};
    checks++;
    if (got !== exp) $display("FAIL reset_mid_state: got %h expected %h", got, exp);
    else passed++;
    for (int e = 0; e < DEPTH; e++) vecs[0][e] = 32'd5;
    run_vectors(1, 30, 0, 0);
    checks++;
    if (rec_data.size() !== DEPTH) $display("FAIL reset_mid_count: got %0d expected %0d", rec_data.size(), DEPTH);
    else passed++;
    for (int i = 0; i < rec_data.size(); i++) begin
      g2 = {rec_data[i], rec_idx[i], rec_last[i]};
      e2 = {32'd5, 3'(i), (i == DEPTH - 1)};
      checks++;
      if (g2 !== e2) $display("FAIL reset_mid_elem%0d: got %h expected %h", i, g2, e2);
      else passed++;
    end
  endtask

  task automatic test_extremes();
    logic [WIDTH+IDXW:0] got, exp;
    for (int e = 0; e < DEPTH; e++) vecs[0][e] = (e == DEPTH - 1) ? 32'hFFFF_FFFF : 32'd0;
    run_vectors(1, 30, 0, 0);
    checks++;
    if (rec_data.size() !== DEPTH) $display("FAIL extremes_count: got %0d expected %0d", rec_data.size(), DEPTH);
    else passed++;
    for (int i = 0; i < rec_data.size(); i++) begin
      got = {rec_data[i], rec_idx[i], rec_last[i]};
      exp = {((i == DEPTH - 1) ? 32'hFFFF_FFFF : 32'd0), 3'(i), (i == DEPTH - 1)};
      checks++;
      if (got !== exp) $display("FAIL extremes_elem%0d: got %h expected %h", i, got, exp);
      else passed++;
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    test_reset();
    test_full_rate();
    test_backpressure();
    test_back_to_back();
    test_hold_buffer();
    test_reset_mid();
    test_extremes();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
